aes_word_loader: RTL and testbench

- Upstream/downstream adaptor for the iterative AES-128 encryption core.
- Collects plaintext and key as 32-bit words over a valid/ready stream and presents them as 128-bit buses.
- Issues a one-cycle start pulse, waits the core's fixed latency, then captures the 128-bit ciphertext and returns it over a valid/ready output stream.
- Lets the core sit behind a narrow bus interface.

---
 rtl/aes_word_loader_pkg.sv | 27 ++
 rtl/aes_word_shift.sv | 34 +++
 rtl/aes_word_loader.sv | 138 +++++++++++++
 tb/tb_aes_word_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_word_loader_pkg.sv
// Shared widths, FSM states and defaults for the AES-128 word loader.
// Imported by the loader top and its word-assembly sub-module.
package aes_word_loader_pkg;

    localparam int AES_BLOCK_W          = 128;
    localparam int AES_WORD_W           = 32;
    localparam int WORDS_PER_BLOCK      = 4;
    localparam int WORD_IDX_W           = $clog2(WORDS_PER_BLOCK);
    localparam int DEFAULT_CORE_LATENCY = 11;

    localparam logic [WORD_IDX_W-1:0] FIRST_WORD = WORD_IDX_W'(0);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD  = WORD_IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        LOAD_PT  = 3'd0,
        LOAD_KEY = 3'd1,
        START    = 3'd2,
        WAIT     = 3'd3,
        HOLD     = 3'd4
    } loader_state_e;

    // True when an accepted word at this index completes a 128-bit block.
    function automatic logic is_last_word(input logic [WORD_IDX_W-1:0] idx);
        return (idx == LAST_WORD);
    endfunction

endpackage

// File: rtl/aes_word_shift.sv
// Assembles four 32-bit words into a 128-bit block, most-significant word first.
// The word index wraps after the last word so the next block starts at word 0.
module aes_word_shift
    import aes_word_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AES_WORD_W-1:0]  wr_data,
    output logic [AES_BLOCK_W-1:0] block,
    output logic [WORD_IDX_W-1:0]  count
);

    logic [WORDS_PER_BLOCK-1:0][AES_WORD_W-1:0] words_r;
    logic [WORD_IDX_W-1:0]                      count_r;

    // Word i lands in the slot holding block bits [127-32i -: 32].
    always_ff @(posedge clk) begin
        if (rst) begin
            words_r <= '0;
            count_r <= FIRST_WORD;
        end else if (wr_en) begin
            words_r[LAST_WORD - count_r] <= wr_data;
            count_r                      <= count_r + WORD_IDX_W'(1);
        end else begin
            words_r <= words_r;
            count_r <= count_r;
        end
    end

    assign block = words_r;
    assign count = count_r;

endmodule

// File: rtl/aes_word_loader.sv
// Narrow-bus adaptor for an iterative AES-128 core: gathers plaintext/key words,
// pulses the core, waits its fixed latency and hands back the ciphertext.
module aes_word_loader
    import aes_word_loader_pkg::*;
#(
    parameter int CORE_LATENCY = DEFAULT_CORE_LATENCY,
    parameter int CNT_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_WORD_W-1:0]  in_data,
    input  logic                   in_keep_key,
    output logic [AES_BLOCK_W-1:0] plane,
    output logic [AES_BLOCK_W-1:0] key,
    output logic                   cal_en,
    input  logic [AES_BLOCK_W-1:0] cipher_text,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(CORE_LATENCY - 1);

    loader_state_e         state_r;
    logic [CNT_W-1:0]      lat_cnt_r;
    logic                  key_loaded_r;
    logic                  keep_key_r;

    logic                  in_ready_s;
    logic                  xfer_s;
    logic                  pt_wr_s;
    logic                  key_wr_s;
    logic [WORD_IDX_W-1:0] pt_cnt_s;
    logic [WORD_IDX_W-1:0] key_cnt_s;

    // Ready follows out_ready in HOLD so the next block's first word rides the drain handshake.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                LOAD_PT:  in_ready_s = 1'b1;
                LOAD_KEY: in_ready_s = 1'b1;
                HOLD:     in_ready_s = out_ready;
                default:  in_ready_s = 1'b0;
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign xfer_s   = in_valid & in_ready_s;
    assign pt_wr_s  = xfer_s & ((state_r == LOAD_PT) | (state_r == HOLD));
    assign key_wr_s = xfer_s & (state_r == LOAD_KEY);
    assign busy     = ~((state_r == LOAD_PT) & (pt_cnt_s == FIRST_WORD));

    aes_word_shift u_pt_shift (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pt_wr_s),
        .wr_data (in_data),
        .block   (plane),
        .count   (pt_cnt_s)
    );

    aes_word_shift u_key_shift (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (key_wr_s),
        .wr_data (in_data),
        .block   (key),
        .count   (key_cnt_s)
    );

    // Block sequencer: load, start pulse, latency wait, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= LOAD_PT;
            lat_cnt_r    <= '0;
            key_loaded_r <= 1'b0;
            keep_key_r   <= 1'b0;
            cal_en       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            cal_en <= 1'b0;
            if (pt_wr_s && (pt_cnt_s == FIRST_WORD)) begin
                keep_key_r <= in_keep_key;
            end
            case (state_r)
                LOAD_PT: begin
                    if (pt_wr_s && is_last_word(pt_cnt_s)) begin
                        // A keep request is only honoured once a key has actually been loaded.
                        if (keep_key_r && key_loaded_r) begin
                            state_r <= START;
                            cal_en  <= 1'b1;
                        end else begin
                            state_r <= LOAD_KEY;
                        end
                    end
                end
                LOAD_KEY: begin
                    if (key_wr_s && is_last_word(key_cnt_s)) begin
                        key_loaded_r <= 1'b1;
                        state_r      <= START;
                        cal_en       <= 1'b1;
                    end
                end
                START: begin
                    lat_cnt_r <= LAT_LOAD;
                    state_r   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt_r == CNT_W'(0)) begin
                        out_data  <= cipher_text;
                        out_valid <= 1'b1;
                        state_r   <= HOLD;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= LOAD_PT;
                    end
                end
                default: begin
                    state_r <= LOAD_PT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader with a behavioural AES-128 core
// attached; expected ciphertexts come from known vectors and the bench's own AES model.
module tb_aes_word_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_keep_key;
    logic [127:0] plane;
    logic [127:0] key;
    logic         cal_en;
    logic [127:0] cipher_text;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    always #5 clk = ~clk;

    aes_word_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_keep_key (in_keep_key),
        .plane       (plane),
        .key         (key),
        .cal_en      (cal_en),
        .cipher_text (cipher_text),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rcon [10];
        logic [31:0]  tmp;
        logic [127:0] rk;
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon[i/4-1], 24'h000000};
            w[i] = w[i-4] ^ tmp;
        end
        rk = {w[0], w[1], w[2], w[3]};
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ rk[127-8*n -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) t[n] = sbox[s[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[127-8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    // ---------------- core model: result valid only 11 cycles after cal_en ----------------
    int           core_cnt = 0;
    logic [127:0] core_res = '0;
    int           cal_cnt  = 0;

    always @(posedge clk) begin
        if (cal_en) begin
            core_cnt <= 1;
            core_res <= aes_enc(plane, key);
            cal_cnt  <= cal_cnt + 1;
        end else if (core_cnt != 0 && core_cnt < 20) begin
            core_cnt <= core_cnt + 1;
        end
    end

    assign cipher_text = (core_cnt == 11) ? core_res : ~core_res;

    // ---------------- checking helpers ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [127:0] tb_key        = '0;
    bit           tb_key_loaded = 1'b0;

    task automatic send_word(input logic [31:0] d, input logic kp, input bit gaps);
        bit acc;
        if (gaps) begin
            for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(negedge clk);
            end
        end
        in_valid    = 1'b1;
        in_data     = d;
        in_keep_key = kp;
        acc         = 1'b0;
        for (int n = 0; n < 40 && !acc; n++) begin
            #1 acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        check_bit("word_accept", acc, 1'b1);
    endtask

    task automatic send_block(input logic [127:0] pt, input logic [127:0] k,
                              input logic keep, input bit gaps);
        for (int i = 0; i < 4; i++)
            send_word(pt[127-32*i -: 32], (i == 0) ? keep : 1'($urandom_range(1, 0)), gaps);
        if (!(keep && tb_key_loaded)) begin
            #1;
            check_bit("load_key_ready", in_ready, 1'b1);
            check_bit("load_key_no_cal", cal_en, 1'b0);
            for (int i = 0; i < 4; i++) send_word(k[127-32*i -: 32], 1'($urandom_range(1, 0)), gaps);
            tb_key        = k;
            tb_key_loaded = 1'b1;
        end
    endtask

    // Waits for cal_en, measures result latency, checks hold/back-pressure; leaves DUT in HOLD.
    task automatic await_result(input logic [127:0] pt, input logic [127:0] exp, input int bp);
        int n;
        int lat;
        int c0;
        c0 = cal_cnt;
        n  = 0;
        while (!cal_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit("cal_en_seen", cal_en, 1'b1);
        check_vec("plane_at_start", plane, pt);
        check_vec("key_at_start", key, tb_key);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check_vec("plane_stable", plane, pt);
            check_vec("key_stable", key, tb_key);
        end while (!out_valid && lat < 40);
        check_vec("latency", 128'(lat), 128'(12));
        check_vec("out_data", out_data, exp);
        check_bit("busy_hold", busy, 1'b1);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_bit("bp_out_valid", out_valid, 1'b1);
            check_vec("bp_out_data", out_data, exp);
            check_bit("bp_in_ready", in_ready, 1'b0);
        end
        check_vec("single_cal_en", 128'(cal_cnt - c0), 128'(1));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        #1 check_bit("hold_in_ready", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        check_bit("drain_out_valid", out_valid, 1'b0);
        check_bit("drain_busy", busy, 1'b0);
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] k;
        logic         keep;
        logic [127:0] exp;
        int           bp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [127:0] pt;
        logic [127:0] k;
        logic [127:0] exp;
        logic         kp;
        for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));

        // keep_key on the very first block must still pull in the key words
        vecs[0] = '{FIPS_PT, FIPS_KEY, 1'b1, FIPS_CT, 0};
        vecs[1] = '{FIPS_PT, 128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b1, FIPS_CT, 20};
        vecs[2] = '{B_PT, B_KEY, 1'b0, B_CT, 2};
        vecs[3] = '{FIPS_PT, 128'h0, 1'b1, aes_enc(FIPS_PT, B_KEY), 0};
        vecs[4] = '{B_PT, FIPS_KEY, 1'b0, aes_enc(B_PT, FIPS_KEY), 1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep_key = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1 check_bit("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_vec("reset_plane", plane, 128'h0);
        check_vec("reset_key", key, 128'h0);
        check_bit("reset_cal_en", cal_en, 1'b0);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_vec("reset_out_data", out_data, 128'h0);
        check_bit("reset_busy", busy, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_block(vecs[i].pt, vecs[i].k, vecs[i].keep, 1'b0);
            await_result(vecs[i].pt, vecs[i].exp, vecs[i].bp);
            handshake();
        end

        // reset while WAIT counter is at 5
        send_block(B_PT, FIPS_KEY, 1'b0, 1'b0);
        for (int n = 0; n < 20 && !cal_en; n++) @(negedge clk);
        check_bit("mid_cal_en", cal_en, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1 check_bit("mid_rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_bit("mid_rst_out_valid", out_valid, 1'b0);
        check_vec("mid_rst_plane", plane, 128'h0);
        check_vec("mid_rst_key", key, 128'h0);
        check_bit("mid_rst_busy", busy, 1'b0);
        tb_key        = '0;
        tb_key_loaded = 1'b0;
        repeat (15) @(negedge clk);
        check_bit("stale_result_dropped", out_valid, 1'b0);
        send_block(B_PT, B_KEY, 1'b1, 1'b0);
        await_result(B_PT, B_CT, 0);
        handshake();

        // randomized blocks with ~50% in_valid duty
        for (int b = 0; b < 6; b++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            k   = {$urandom, $urandom, $urandom, $urandom};
            kp  = 1'($urandom_range(1, 0));
            exp = aes_enc(pt, (kp && tb_key_loaded) ? tb_key : k);
            send_block(pt, k, kp, 1'b1);
            await_result(pt, exp, $urandom_range(3, 0));
            handshake();
        end

        // next block's first word accepted in the drain handshake cycle
        send_block(FIPS_PT, FIPS_KEY, 1'b0, 1'b0);
        await_result(FIPS_PT, FIPS_CT, 1);
        pt          = B_PT;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_data     = pt[127:96];
        in_keep_key = 1'b1;
        #1 check_bit("ovl_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_bit("ovl_out_valid", out_valid, 1'b0);
        check_vec("ovl_word0", 128'(plane[127:96]), 128'(pt[127:96]));
        check_bit("ovl_busy", busy, 1'b1);
        for (int i = 1; i < 4; i++) send_word(pt[127-32*i -: 32], 1'b0, 1'b0);
        await_result(pt, aes_enc(pt, FIPS_KEY), 0);
        handshake();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
